// File: rtl/robo_step_scheduler.sv
// Robot step sequencer: triggers one Robo step per frame interval or manual request,
// reads the ahead/left/current map cells, pulses AtivaRobo and applies the returned command.
module robo_step_scheduler #(
  parameter int FRAMES_PER_STEP = 30,
  parameter int GRID_COLS       = 20,
  parameter int GRID_ROWS       = 15,
  parameter int RESET_COL       = 1,
  parameter int RESET_LIN       = 1
) (
  input  logic       Clock50,
  input  logic       Reset,
  input  logic       v_sync,
  input  logic       ModoAuto,
  input  logic       StepReq,
  output logic [4:0] MapCol,
  output logic [3:0] MapLin,
  input  logic [1:0] MapData,
  output logic       ClearRubble,
  output logic       head,
  output logic       left,
  output logic       under,
  output logic       barrier,
  output logic       AtivaRobo,
  input  logic       avancar,
  input  logic       girar,
  input  logic       remover,
  output logic [4:0] RoboCol,
  output logic [3:0] RoboLin,
  output logic [1:0] OrientacaoRobo,
  output logic       Busy
);

  localparam logic [3:0] S_IDLE     = 4'd0;
  localparam logic [3:0] S_RD_HEAD  = 4'd1;
  localparam logic [3:0] S_RD_LEFT  = 4'd2;
  localparam logic [3:0] S_RD_UNDER = 4'd3;
  localparam logic [3:0] S_CAP      = 4'd4;
  localparam logic [3:0] S_PULSE    = 4'd5;
  localparam logic [3:0] S_SETTLE1  = 4'd6;
  localparam logic [3:0] S_SETTLE2  = 4'd7;
  localparam logic [3:0] S_APPLY    = 4'd8;

  localparam int CW = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(FRAMES_PER_STEP - 1);

  // Neighbour of (col,lin) in direction dir, packed as {out_of_grid, col, lin}
  function automatic logic [9:0] neighbour(input logic [4:0] col, input logic [3:0] lin,
                                           input logic [1:0] dir);
    logic       oob;
    logic [4:0] c;
    logic [3:0] l;
    oob = 1'b0;
    c   = col;
    l   = lin;
    case (dir)
      2'd0: if (lin == 4'd0) oob = 1'b1; else l = lin - 4'd1;
      2'd1: if (col == 5'(GRID_COLS - 1)) oob = 1'b1; else c = col + 5'd1;
      2'd2: if (lin == 4'(GRID_ROWS - 1)) oob = 1'b1; else l = lin + 4'd1;
      2'd3: if (col == 5'd0) oob = 1'b1; else c = col - 5'd1;
      default: oob = 1'b1;
    endcase
    return {oob, c, l};
  endfunction

  logic [3:0]    r_state;
  logic [1:0]    r_vs_sync, r_rq_sync;
  logic          r_vs_d, r_rq_d;
  logic [CW-1:0] r_cnt;
  logic          r_pend;
  logic [4:0]    r_col, r_map_col;
  logic [3:0]    r_lin, r_map_lin;
  logic [1:0]    r_ori;
  logic          r_head, r_left, r_under, r_barrier;
  logic          r_ativa, r_clear, r_busy;

  logic          w_tick, w_req, w_auto, w_trigger;
  logic [3:0]    w_next_state;
  logic [9:0]    w_ahead, w_left_cell;
  logic [4:0]    w_map_col;
  logic [3:0]    w_map_lin;

  assign w_tick      = r_vs_d & ~r_vs_sync[1];
  assign w_req       = ~r_rq_d & r_rq_sync[1];
  assign w_auto      = ModoAuto & w_tick & (r_cnt == CNT_LAST);
  assign w_trigger   = (r_state == S_IDLE) & (w_auto | w_req | r_pend);
  assign w_ahead     = neighbour(r_col, r_lin, r_ori);
  assign w_left_cell = neighbour(r_col, r_lin, r_ori - 2'd1);

  // Two-flop synchronisers plus one delay flop for edge detection
  always_ff @(posedge Clock50 or negedge Reset) begin
    if (!Reset) begin
      r_vs_sync <= 2'b00;
      r_vs_d    <= 1'b0;
      r_rq_sync <= 2'b00;
      r_rq_d    <= 1'b0;
    end else begin
      r_vs_sync <= {r_vs_sync[0], v_sync};
      r_vs_d    <= r_vs_sync[1];
      r_rq_sync <= {r_rq_sync[0], StepReq};
      r_rq_d    <= r_rq_sync[1];
    end
  end

  // Frame counter and single-deep pending manual request
  always_ff @(posedge Clock50 or negedge Reset) begin
    if (!Reset) begin
      r_cnt  <= '0;
      r_pend <= 1'b0;
    end else begin
      if (!ModoAuto) r_cnt <= '0;
      else if (w_tick) r_cnt <= (r_cnt == CNT_LAST) ? '0 : r_cnt + CW'(1);
      if (r_state != S_IDLE) begin
        if (w_req) r_pend <= 1'b1;
      end else begin
        r_pend <= 1'b0;
      end
    end
  end

  // Step sequence, one state per cycle
  always_comb begin
    w_next_state = S_IDLE;
    case (r_state)
      S_IDLE:     if (w_trigger) w_next_state = S_RD_HEAD; else w_next_state = S_IDLE;
      S_RD_HEAD:  w_next_state = S_RD_LEFT;
      S_RD_LEFT:  w_next_state = S_RD_UNDER;
      S_RD_UNDER: w_next_state = S_CAP;
      S_CAP:      w_next_state = S_PULSE;
      S_PULSE:    w_next_state = S_SETTLE1;
      S_SETTLE1:  w_next_state = S_SETTLE2;
      S_SETTLE2:  w_next_state = S_APPLY;
      S_APPLY:    w_next_state = S_IDLE;
      default:    w_next_state = S_IDLE;
    endcase
  end

  // Map address for the coming state; out-of-grid neighbours fall back to the current cell
  always_comb begin
    w_map_col = r_col;
    w_map_lin = r_lin;
    if (w_next_state == S_RD_HEAD && !w_ahead[9]) begin
      w_map_col = w_ahead[8:4];
      w_map_lin = w_ahead[3:0];
    end else if (w_next_state == S_RD_LEFT && !w_left_cell[9]) begin
      w_map_col = w_left_cell[8:4];
      w_map_lin = w_left_cell[3:0];
    end else begin
      w_map_col = r_col;
      w_map_lin = r_lin;
    end
  end

  // State register with registered Busy, AtivaRobo and map address
  always_ff @(posedge Clock50 or negedge Reset) begin
    if (!Reset) begin
      r_state   <= S_IDLE;
      r_busy    <= 1'b0;
      r_ativa   <= 1'b0;
      r_map_col <= 5'd0;
      r_map_lin <= 4'd0;
    end else begin
      r_state   <= w_next_state;
      r_busy    <= (w_next_state != S_IDLE);
      r_ativa   <= (r_state == S_CAP);
      r_map_col <= w_map_col;
      r_map_lin <= w_map_lin;
    end
  end

  // Sensor capture; MapData lags the address by one cycle
  always_ff @(posedge Clock50 or negedge Reset) begin
    if (!Reset) begin
      r_head    <= 1'b0;
      r_barrier <= 1'b0;
      r_left    <= 1'b0;
      r_under   <= 1'b0;
    end else begin
      case (r_state)
        S_RD_LEFT: begin
          r_head    <= w_ahead[9] | MapData[0];
          r_barrier <= ~w_ahead[9] & (MapData == 2'b11);
        end
        S_RD_UNDER: r_left  <= w_left_cell[9] | MapData[0];
        S_CAP:      r_under <= (MapData == 2'b10);
        default:    r_head  <= r_head;
      endcase
    end
  end

  // Command application: remover > girar > avancar
  always_ff @(posedge Clock50 or negedge Reset) begin
    if (!Reset) begin
      r_col   <= 5'(RESET_COL);
      r_lin   <= 4'(RESET_LIN);
      r_ori   <= 2'b01;
      r_clear <= 1'b0;
    end else begin
      r_clear <= (r_state == S_APPLY) & remover;
      if (r_state == S_APPLY && !remover) begin
        if (girar) begin
          r_ori <= r_ori - 2'd1;
        end else if (avancar && !r_head) begin
          r_col <= w_ahead[8:4];
          r_lin <= w_ahead[3:0];
        end
      end
    end
  end

  assign MapCol         = r_map_col;
  assign MapLin         = r_map_lin;
  assign ClearRubble    = r_clear;
  assign head           = r_head;
  assign left           = r_left;
  assign under          = r_under;
  assign barrier        = r_barrier;
  assign AtivaRobo      = r_ativa;
  assign RoboCol        = r_col;
  assign RoboLin        = r_lin;
  assign OrientacaoRobo = r_ori;
  assign Busy           = r_busy;

endmodule

// File: tb/tb_robo_step_scheduler.sv
// Self-checking bench for robo_step_scheduler: directed table, corner sequences and
// randomized steps against a grid-level reference model.
module tb_robo_step_scheduler;

  logic       Clock50 = 1'b0;
  logic       Reset, v_sync, ModoAuto, StepReq;
  logic [4:0] MapCol;
  logic [3:0] MapLin;
  logic [1:0] MapData;
  logic       ClearRubble, head, left, under, barrier, AtivaRobo;
  logic       avancar, girar, remover;
  logic [4:0] RoboCol;
  logic [3:0] RoboLin;
  logic [1:0] OrientacaoRobo;
  logic       Busy;

  always #10 Clock50 = ~Clock50;

  robo_step_scheduler #(.FRAMES_PER_STEP(3), .GRID_COLS(20), .GRID_ROWS(15),
                        .RESET_COL(1), .RESET_LIN(1)) dut (
    .Clock50(Clock50), .Reset(Reset), .v_sync(v_sync), .ModoAuto(ModoAuto),
    .StepReq(StepReq), .MapCol(MapCol), .MapLin(MapLin), .MapData(MapData),
    .ClearRubble(ClearRubble), .head(head), .left(left), .under(under),
    .barrier(barrier), .AtivaRobo(AtivaRobo), .avancar(avancar), .girar(girar),
    .remover(remover), .RoboCol(RoboCol), .RoboLin(RoboLin),
    .OrientacaoRobo(OrientacaoRobo), .Busy(Busy));

  logic [1:0] grid [0:19][0:14];

  // Synchronous map store: data one cycle after address
  always @(posedge Clock50) begin
    if (MapCol < 5'd20 && MapLin < 4'd15) MapData <= grid[MapCol][MapLin];
    else MapData <= 2'b00;
  end

  int errors = 0, checks = 0;
  int pulses = 0, clears = 0, clr_col = -1, clr_lin = -1;
  int m_col, m_lin, m_ori;

  typedef struct {
    bit av, gi, rm;
    int col, lin, ori;
    bit h, l, u, b;
  } vec_t;
  vec_t tbl[15];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock50);
    @(negedge Clock50);
    if (AtivaRobo === 1'b1) pulses++;
    if (ClearRubble === 1'b1) begin
      clears++;
      clr_col = int'(MapCol);
      clr_lin = int'(MapLin);
      if (MapCol < 5'd20 && MapLin < 4'd15) grid[MapCol][MapLin] = 2'b00;
    end
  endtask

  task automatic clear_grid();
    for (int c = 0; c < 20; c++)
      for (int l = 0; l < 15; l++) grid[c][l] = 2'b00;
  endtask

  task automatic check_pose(input string tag, input int c, input int l, input int o);
    check({tag, "_col"}, int'(RoboCol), c);
    check({tag, "_lin"}, int'(RoboLin), l);
    check({tag, "_ori"}, int'(OrientacaoRobo), o);
  endtask

  task automatic check_sensors(input string tag, input bit h, input bit l, input bit u, input bit b);
    check({tag, "_head"}, int'(head), int'(h));
    check({tag, "_left"}, int'(left), int'(l));
    check({tag, "_under"}, int'(under), int'(u));
    check({tag, "_barrier"}, int'(barrier), int'(b));
  endtask

  // One manual step; reports the tick of the AtivaRobo pulse and of the first pose change
  task automatic do_step(input bit av, input bit gi, input bit rm,
                         output int pulse_at, output int upd_at);
    int p0;
    logic [10:0] pos0;
    bit done;
    avancar = av; girar = gi; remover = rm;
    p0 = pulses; pos0 = {RoboCol, RoboLin, OrientacaoRobo};
    pulse_at = 0; upd_at = 0; done = 1'b0;
    StepReq = 1'b1;
    for (int i = 1; i <= 30 && !done; i++) begin
      tick();
      if (i == 3) StepReq = 1'b0;
      if (AtivaRobo === 1'b1 && pulse_at == 0) pulse_at = i;
      if ({RoboCol, RoboLin, OrientacaoRobo} != pos0 && upd_at == 0) upd_at = i;
      if (i >= 8 && Busy === 1'b0) done = 1'b1;
    end
    check("step_done", int'(done), 1);
    check("step_pulses", pulses - p0, 1);
    avancar = 1'b0; girar = 1'b0; remover = 1'b0;
  endtask

  // One v_sync fall; returns the tick of the first AtivaRobo and the number of high samples
  task automatic frame(output int first, output int highs);
    first = 0; highs = 0;
    v_sync = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (i == 3) v_sync = 1'b1;
      if (AtivaRobo === 1'b1) begin
        highs++;
        if (first == 0) first = i;
      end
    end
  endtask

  function automatic void nbr(input int c, input int l, input int o,
                              output int nc, output int nl, output bit oob);
    nc = c; nl = l;
    case (o & 3)
      0: nl = l - 1;
      1: nc = c + 1;
      2: nl = l + 1;
      default: nc = c - 1;
    endcase
    oob = (nc < 0) || (nc >= 20) || (nl < 0) || (nl >= 15);
  endfunction

  function automatic int code_at(input int c, input int l);
    return int'(grid[c][l]);
  endfunction

  initial begin
    int pa, ua, first, highs, p0, c0;
    int ac, al, lc, ll, ca, cl;
    bit aoob, loob, eh, el, eu, eb, av, gi, rm;
    int pc, pl;

    tbl[0]  = '{1, 0, 0, 2, 1, 1, 0, 0, 0, 0};
    tbl[1]  = '{0, 1, 0, 2, 1, 0, 0, 0, 0, 0};
    tbl[2]  = '{1, 0, 0, 2, 0, 0, 0, 0, 0, 0};
    tbl[3]  = '{0, 1, 0, 2, 0, 3, 1, 0, 0, 0};
    tbl[4]  = '{1, 0, 0, 1, 0, 3, 0, 0, 0, 0};
    tbl[5]  = '{1, 0, 0, 0, 0, 3, 0, 0, 0, 0};
    tbl[6]  = '{0, 1, 0, 0, 0, 2, 1, 0, 0, 0};
    tbl[7]  = '{0, 1, 0, 0, 0, 1, 0, 0, 0, 0};
    tbl[8]  = '{0, 1, 0, 0, 0, 0, 0, 1, 0, 0};
    tbl[9]  = '{1, 0, 0, 0, 0, 0, 1, 1, 0, 0};
    tbl[10] = '{0, 0, 0, 0, 0, 0, 1, 1, 0, 0};
    tbl[11] = '{0, 1, 0, 0, 0, 3, 1, 1, 0, 0};
    tbl[12] = '{0, 1, 0, 0, 0, 2, 1, 0, 0, 0};
    tbl[13] = '{0, 1, 0, 0, 0, 1, 0, 0, 0, 0};
    tbl[14] = '{0, 1, 0, 0, 0, 0, 0, 1, 0, 0};

    clear_grid();
    Reset = 1'b0; v_sync = 1'b1; ModoAuto = 1'b0; StepReq = 1'b0;
    avancar = 1'b0; girar = 1'b0; remover = 1'b0;
    repeat (3) tick();
    check_pose("rst", 1, 1, 1);
    check("rst_busy", int'(Busy), 0);
    check("rst_ativa", int'(AtivaRobo), 0);
    check("rst_clear", int'(ClearRubble), 0);
    check("rst_mapcol", int'(MapCol), 0);
    check("rst_maplin", int'(MapLin), 0);
    check_sensors("rst", 0, 0, 0, 0);
    Reset = 1'b1;
    repeat (3) tick();

    // Automatic stepping: pulses only on every third frame
    ModoAuto = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      frame(first, highs);
      if (k % 3 == 0) begin
        check("auto_pulse_at", first, 7);
        check("auto_pulse_width", highs, 1);
      end else begin
        check("auto_no_pulse", highs, 0);
      end
    end
    ModoAuto = 1'b0;
    repeat (3) tick();
    check_pose("auto", 1, 1, 1);

    // Directed walk on an empty map
    pc = 1; pl = 1;
    for (int i = 0; i < 15; i++) begin
      do_step(tbl[i].av, tbl[i].gi, tbl[i].rm, pa, ua);
      check("tbl_pulse_at", pa, 7);
      if (tbl[i].col != pc || tbl[i].lin != pl) check("tbl_move_at", ua, 11);
      check_pose("tbl", tbl[i].col, tbl[i].lin, tbl[i].ori);
      check_sensors("tbl", tbl[i].h, tbl[i].l, tbl[i].u, tbl[i].b);
      pc = tbl[i].col; pl = tbl[i].lin;
    end

    // Reset in the middle of a remover step
    c0 = clears; p0 = pulses;
    avancar = 1'b1; remover = 1'b1; StepReq = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      tick();
      if (i == 3) StepReq = 1'b0;
    end
    Reset = 1'b0;
    tick();
    check_pose("midrst", 1, 1, 1);
    check("midrst_busy", int'(Busy), 0);
    check("midrst_ativa", int'(AtivaRobo), 0);
    check_sensors("midrst", 0, 0, 0, 0);
    Reset = 1'b1;
    repeat (20) tick();
    avancar = 1'b0; remover = 1'b0;
    check("midrst_clears", clears - c0, 0);
    check("midrst_pulses", pulses - p0, 0);
    check_pose("midrst_after", 1, 1, 1);

    // Rubble underneath, barrier ahead, remover and avancar together
    grid[1][1] = 2'b10; grid[2][1] = 2'b11;
    c0 = clears;
    do_step(1, 0, 1, pa, ua);
    check_sensors("rubble", 1, 0, 1, 1);
    check("rubble_clears", clears - c0, 1);
    check("rubble_col", clr_col, 1);
    check("rubble_lin", clr_lin, 1);
    check("rubble_cell", int'(grid[1][1]), 0);
    check_pose("rubble", 1, 1, 1);
    grid[2][1] = 2'b00;

    // Two extra request edges while busy yield one extra step
    p0 = pulses;
    girar = 1'b1; StepReq = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (i == 2 || i == 4 || i == 6) StepReq = 1'b0;
      if (i == 3 || i == 5) StepReq = 1'b1;
    end
    girar = 1'b0;
    check("dbl_pulses", pulses - p0, 2);
    check("dbl_busy", int'(Busy), 0);
    check_pose("dbl", 1, 1, 3);

    // Randomized steps against the reference model
    m_col = 1; m_lin = 1; m_ori = 3;
    for (int c = 0; c < 20; c++)
      for (int l = 0; l < 15; l++)
        grid[c][l] = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(0, 3)) : 2'b00;
    for (int s = 0; s < 40; s++) begin
      av = ($urandom_range(0, 3) != 0);
      gi = ($urandom_range(0, 3) == 0);
      rm = ($urandom_range(0, 5) == 0);
      nbr(m_col, m_lin, m_ori, ac, al, aoob);
      nbr(m_col, m_lin, (m_ori + 3) % 4, lc, ll, loob);
      ca = aoob ? 0 : code_at(ac, al);
      cl = loob ? 0 : code_at(lc, ll);
      eh = aoob || ca == 1 || ca == 3;
      eb = !aoob && ca == 3;
      el = loob || cl == 1 || cl == 3;
      eu = (code_at(m_col, m_lin) == 2);
      c0 = clears;
      do_step(av, gi, rm, pa, ua);
      check_sensors("rnd", eh, el, eu, eb);
      if (rm) begin
        check("rnd_clear_col", clr_col, m_col);
        check("rnd_clear_lin", clr_lin, m_lin);
      end else if (gi) begin
        m_ori = (m_ori + 3) % 4;
      end else if (av && !eh) begin
        m_col = ac; m_lin = al;
      end
      check("rnd_clears", clears - c0, int'(rm));
      check_pose("rnd", m_col, m_lin, m_ori);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/robo_step_scheduler.md
Name: robo_step_scheduler

Overview:
- Sequences one robot step per trigger, either automatically every FRAMES_PER_STEP frames or on a manual step request from the joystick path.
- Per step: reads three map cells (ahead, left, current), drives the Robo FSM sensor inputs, then issues a single AtivaRobo clock pulse.
- Samples the Robo commands and applies them: updates sprite grid position and orientation, or strobes rubble removal.
- Sits between Controle/v_sync, the map store, Robo and Grafico.

Parameters:
- FRAMES_PER_STEP, 30, v_sync frames between automatic steps (≥1).
- GRID_COLS, 20, map columns.
- GRID_ROWS, 15, map rows.
- RESET_COL, 1, column after reset.
- RESET_LIN, 1, row after reset.

Ports:
- Clock50  in  1  system clock (50 MHz).
- Reset  in  1  asynchronous reset, active-low.
- v_sync  in  1  VGA vertical sync (active-low pulse, async to Clock50).
- ModoAuto  in  1  1 = automatic stepping; 0 = manual.
- StepReq  in  1  manual step request, level from controller.
- MapCol  out  5  map read/clear column address.
- MapLin  out  4  map read/clear row address.
- MapData  in  2  cell code, valid 1 cycle after address: 00 free, 01 wall, 10 rubble, 11 barrier.
- ClearRubble  out  1  1-cycle strobe: clear cell at MapCol/MapLin.
- head  out  1  sensor to Robo.
- left  out  1  sensor to Robo.
- under  out  1  sensor to Robo.
- barrier  out  1  sensor to Robo.
- AtivaRobo  out  1  1-cycle clock pulse to Robo.
- avancar  in  1  Robo command.
- girar  in  1  Robo command.
- remover  in  1  Robo command.
- RoboCol  out  5  robot grid column.
- RoboLin  out  4  robot grid row.
- OrientacaoRobo  out  2  00 N, 01 E, 10 S, 11 W.
- Busy  out  1  step in progress.

Behaviour:
- Reset (async, Reset=0):
  - All outputs 0 except RoboCol=RESET_COL, RoboLin=RESET_LIN, OrientacaoRobo=01.
  - FSM goes to IDLE; counter and pending flag cleared.
  - Reset mid-step aborts the step with no position change and no ClearRubble.
- Synchronisers: v_sync and StepReq each pass through 2 FFs.
  - Frame tick = synchronised v_sync falling edge.
  - Step request = synchronised StepReq rising edge.
- Frame counter:
  - ModoAuto=1: increments on each tick; at FRAMES_PER_STEP-1 it wraps to 0 and raises the auto trigger.
  - ModoAuto=0: counter held at 0.
- Manual request:
  - A step request while Busy sets a pending flag (depth 1; extra requests are lost).
  - Pending is consumed on return to IDLE.
  - A request in IDLE triggers immediately.
- Auto trigger while Busy: dropped.
- Auto trigger and manual request in the same cycle: exactly one step.
- FSM, one state per cycle:
  - IDLE → RD_HEAD on trigger.
  - RD_HEAD: address = cell ahead.
  - RD_LEFT: address = cell to the left (orientation-1 mod 4); capture head data.
  - RD_UNDER: address = current cell; capture left data.
  - CAP: capture under data.
  - PULSE: AtivaRobo=1.
  - SETTLE1, SETTLE2.
  - APPLY → IDLE.
  - Busy=1 in all states except IDLE.
  - Trigger to AtivaRobo = 5 cycles; trigger to position update visible = 9 cycles.
- Sensor decode:
  - head = ahead code ∈ {01, 11} or ahead cell out of grid.
  - barrier = ahead code 11.
  - left = left code ∈ {01, 11} or left cell out of grid.
  - under = current code 10.
  - An out-of-grid address is not driven to the map (MapCol/MapLin hold the current cell); the sensor is forced.
  - Sensors update in the capture cycles and hold stable from PULSE until the next step.
- APPLY, priority remover > girar > avancar:
  - remover: ClearRubble=1 for 1 cycle, MapCol/MapLin = current cell.
  - girar: OrientacaoRobo = OrientacaoRobo-1 mod 4 (N→W→S→E→N).
  - avancar with head=0: move one cell in orientation direction.
  - avancar with head=1: no move.
  - No command: no change.
- Position arithmetic:
  - Column range 0..GRID_COLS-1, row range 0..GRID_ROWS-1; no wrap-around.
  - Edges are walls via the out-of-grid rule.

Test Plan:
- Reset with Reset=0 mid-step → RoboCol=1, RoboLin=1, Orientacao=01, Busy=0, AtivaRobo=0, no ClearRubble.
- ModoAuto=1, FRAMES_PER_STEP=3, 7 v_sync falls → AtivaRobo pulses after falls 3 and 6 only; each pulse 1 cycle wide, 5 cycles after the synchronised edge.
- Manual step, robot at (1,1) facing E, map all 00, Robo asserts avancar → head=0; RoboCol=2 9 cycles after the edge.
- Robot at (0,0) facing N, avancar → head=1, left=1 (W out of grid), barrier=0; position unchanged.
- Current cell 10, ahead cell 11 → under=1, barrier=1, head=1; Robo asserts remover and avancar together → one ClearRubble strobe at (col,lin), no move.
- girar ×4 via manual steps → Orientacao 01→00→11→10→01; two StepReq edges during one Busy step → exactly one extra step follows.
